snake_engine: RTL

Parametrised snake-body engine that replaces the fixed-size movement, growth and collision logic in the greedy-snake game. It owns the playfield geometry, the segment ring buffer, the move-tick generator and the IDLE/RUN/DEAD game state. It answers per-cell pixel queries from the VGA renderer and reports apple-eat and death events to the score, LED and apple logic.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_tick_gen.sv | 30 +++
 rtl/snake_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine.
// Direction, game state and query-result codes plus the reverse-direction helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } st_e;

  localparam logic [1:0] Q_EMPTY = 2'd0;
  localparam logic [1:0] Q_HEAD  = 2'd1;
  localparam logic [1:0] Q_BODY  = 2'd2;

  // up<->down and left<->right differ only in bit 0
  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: counts TICK_DIV cycles while enabled.
// Synchronous clear restarts the period; tick is high on the terminal count.
module snake_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TC) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == TC);

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: ring-buffer body, move/grow/collision and cell queries.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of dying.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 12_500_000,
  parameter int XW       = $clog2(GRID_W),
  parameter int YW       = $clog2(GRID_H),
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir_valid,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic [1:0]    query_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [1:0]    state,
  output logic          ate,
  output logic          dead
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [XW:0]    GW    = (XW+1)'(GRID_W);
  localparam logic [YW:0]    GH    = (YW+1)'(GRID_H);
  localparam logic [LW-1:0]  LMAX  = LW'(MAX_LEN);
  localparam logic [PW-1:0]  PLAST = PW'(MAX_LEN - 1);

  logic [XW-1:0] r_sx [MAX_LEN];
  logic [YW-1:0] r_sy [MAX_LEN];
  logic [PW-1:0] r_hp;
  logic [LW-1:0] r_len;
  logic [1:0]    r_dir, r_pend, r_q;
  logic          r_ate, r_dead;
  st_e           r_state, w_state_nx;

  logic          w_run, w_load, w_tick, w_move;
  logic [XW-1:0] w_hx, w_nx;
  logic [YW-1:0] w_hy, w_ny;
  logic [XW:0]   w_nx_raw;
  logic [YW:0]   w_ny_raw;
  logic          w_wall_hit, w_body, w_hit, w_grow, w_vac;
  logic          w_qhead, w_qbody;
  logic [PW-1:0] w_hp_nx;
  logic [PW-1:0] w_age [MAX_LEN];
  logic          w_act [MAX_LEN];
  logic          w_tail [MAX_LEN];

  function automatic logic [XW-1:0] init_x(input int k);
    return XW'(GRID_W / 2 - INIT_LEN + 1 + k);
  endfunction

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_clr  (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nx = ST_RUN;
      ST_RUN:  if (w_tick && w_hit) w_state_nx = ST_DEAD;
      ST_DEAD: if (start) w_state_nx = ST_RUN;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run  = (r_state == ST_RUN);
    w_load = start && (r_state != ST_RUN);
  end

  assign w_move  = w_tick && w_run;
  assign w_hx    = r_sx[r_hp];
  assign w_hy    = r_sy[r_hp];
  assign w_hp_nx = (r_hp == PLAST) ? '0 : r_hp + PW'(1);

  // Extra top bit turns an underflow at column/row 0 into a large value
  always_comb begin
    w_nx_raw = {1'b0, w_hx};
    w_ny_raw = {1'b0, w_hy};
    unique case (r_pend)
      DIR_UP:    w_ny_raw = {1'b0, w_hy} - (YW+1)'(1);
      DIR_DOWN:  w_ny_raw = {1'b0, w_hy} + (YW+1)'(1);
      DIR_LEFT:  w_nx_raw = {1'b0, w_hx} - (XW+1)'(1);
      DIR_RIGHT: w_nx_raw = {1'b0, w_hx} + (XW+1)'(1);
      default:   w_nx_raw = {1'b0, w_hx};
    endcase
`ifdef SNAKE_WRAP_EN
    if (w_nx_raw == GW)     w_nx = '0;
    else if (w_nx_raw > GW) w_nx = XW'(GRID_W - 1);
    else                    w_nx = w_nx_raw[XW-1:0];
    if (w_ny_raw == GH)     w_ny = '0;
    else if (w_ny_raw > GH) w_ny = YW'(GRID_H - 1);
    else                    w_ny = w_ny_raw[YW-1:0];
    w_wall_hit = 1'b0;
`else
    w_nx = w_nx_raw[XW-1:0];
    w_ny = w_ny_raw[YW-1:0];
    w_wall_hit = (w_nx_raw >= GW) || (w_ny_raw >= GH);
`endif
  end

  assign w_grow = (w_nx == apple_x) && (w_ny == apple_y);
  assign w_vac  = !w_grow || (r_len == LMAX);

  always_comb begin
    for (int j = 0; j < MAX_LEN; j++) begin
      w_age[j] = (r_hp >= PW'(j)) ? r_hp - PW'(j)
                                  : PW'(int'(r_hp) + MAX_LEN - j);
      w_act[j]  = LW'(w_age[j]) < r_len;
      w_tail[j] = LW'(w_age[j]) == (r_len - LW'(1));
    end
  end

  // The tail cell is free to enter when it vacates on this move
  always_comb begin
    w_body  = 1'b0;
    w_qhead = 1'b0;
    w_qbody = 1'b0;
    for (int j = 0; j < MAX_LEN; j++) begin
      if (w_act[j] && !(w_tail[j] && w_vac) &&
          r_sx[j] == w_nx && r_sy[j] == w_ny)
        w_body = 1'b1;
      if (w_act[j] && r_sx[j] == query_x && r_sy[j] == query_y) begin
        if (PW'(j) == r_hp) w_qhead = 1'b1;
        else                w_qbody = 1'b1;
      end
    end
  end

  assign w_hit = w_wall_hit || w_body;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_sx[k] <= init_x(k);
        r_sy[k] <= YW'(GRID_H / 2);
      end
      r_hp   <= PW'(INIT_LEN - 1);
      r_len  <= LW'(INIT_LEN);
      r_dir  <= DIR_RIGHT;
      r_pend <= DIR_RIGHT;
      r_ate  <= 1'b0;
      r_dead <= 1'b0;
      r_q    <= Q_EMPTY;
    end else begin
      r_ate  <= w_move && !w_hit && w_grow;
      r_dead <= w_move && w_hit;
      r_q    <= w_qhead ? Q_HEAD : (w_qbody ? Q_BODY : Q_EMPTY);
      if (w_load) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          r_sx[k] <= init_x(k);
          r_sy[k] <= YW'(GRID_H / 2);
        end
        r_hp   <= PW'(INIT_LEN - 1);
        r_len  <= LW'(INIT_LEN);
        r_dir  <= DIR_RIGHT;
        r_pend <= DIR_RIGHT;
      end else begin
        if (w_move && !w_hit) begin
          r_sx[w_hp_nx] <= w_nx;
          r_sy[w_hp_nx] <= w_ny;
          r_hp          <= w_hp_nx;
          if (w_grow && r_len != LMAX) r_len <= r_len + LW'(1);
        end
        if (w_move) r_dir <= r_pend;
        // A request in the tick cycle is judged against the direction being committed
        if (dir_valid && dir != rev_dir(w_move ? r_pend : r_dir))
          r_pend <= dir;
      end
    end
  end

  assign query_hit = r_q;
  assign head_x    = w_hx;
  assign head_y    = w_hy;
  assign length    = r_len;
  assign state     = r_state;
  assign ate       = r_ate;
  assign dead      = r_dead;

endmodule
